// File: rtl/clm_round_ctrl_pkg.sv
// Shared types and constants for the CLM round controller.
package clm_round_ctrl_pkg;

    localparam int unsigned STAGE_BITS      = 4;
    localparam int unsigned ROUND_BITS      = 4;
    localparam int unsigned WORD_BITS       = 2;
    localparam int unsigned ROUNDS          = 10;
    localparam int unsigned WORDS_PER_STATE = 4;

    typedef logic [STAGE_BITS-1:0] stages_t;
    typedef logic [ROUND_BITS-1:0] round_ctr_t;
    typedef logic [WORD_BITS-1:0]  word_sel_t;

    localparam stages_t ST_IDLE               = 4'd0;
    localparam stages_t ST_CALC_PARAMS        = 4'd1;
    localparam stages_t ST_PREP_DATA          = 4'd2;
    localparam stages_t ST_ADD_ROUND_KEY      = 4'd3;
    localparam stages_t ST_SUB_BYTES          = 4'd4;
    localparam stages_t ST_SHIFT_ROWS         = 4'd5;
    localparam stages_t ST_MIX_COLS           = 4'd6;
    localparam stages_t ST_KEY_EXPAND_WAIT    = 4'd7;
    localparam stages_t ST_ADD_ROUND_KEY_LAST = 4'd8;
    localparam stages_t ST_MOD_P              = 4'd9;
    localparam stages_t ST_PREP_OUTPUT        = 4'd10;

    // Stages in which a key-expansion completion is remembered.
    function automatic logic tracks_key(input stages_t s);
        return s >= ST_SUB_BYTES;
    endfunction

endpackage

// File: rtl/clm_sbox_word_seq.sv
// Word sequencer for the SUB_BYTES stage: steps word_sel through the state
// words, issuing one S-box start (and randomness advance) per word.
module clm_sbox_word_seq
    import clm_round_ctrl_pkg::*;
#(
    parameter int unsigned WORDS = WORDS_PER_STATE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 en,
    input  logic                 sbox_done,
    output logic [WORD_BITS-1:0] word_sel,
    output logic                 sbox_start,
    output logic                 rand_adv,
    output logic                 all_done_c
);

    localparam word_sel_t LAST_WORD = WORD_BITS'(WORDS - 1);

    logic advance_c;

    // Completion of the current word decides between next word and finish.
    always_comb begin
        advance_c  = 1'b0;
        all_done_c = 1'b0;
        if (en && sbox_done) begin
            if (word_sel == LAST_WORD) begin
                all_done_c = 1'b1;
            end else begin
                advance_c = 1'b1;
            end
        end
    end

    // Word index and per-word start strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_sel   <= '0;
            sbox_start <= 1'b0;
            rand_adv   <= 1'b0;
        end else begin
            sbox_start <= go || advance_c;
            rand_adv   <= go || advance_c;
            if (go || all_done_c) begin
                word_sel <= '0;
            end else if (advance_c) begin
                word_sel <= word_sel + WORD_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/clm_round_ctrl.sv
// Main sequencing FSM of the CLM cipher core: walks the stage sequence,
// counts rounds and hands out start strobes to S-box, key expansion and
// parameter extraction.
module clm_round_ctrl
    import clm_round_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drdy_i,
    input  logic                  params_done,
    input  logic                  sbox_done,
    input  logic                  ke_done,
    output logic [STAGE_BITS-1:0] stage,
    output logic [ROUND_BITS-1:0] round,
    output logic [WORD_BITS-1:0]  word_sel,
    output logic                  params_start,
    output logic                  sbox_start,
    output logic                  ke_start,
    output logic                  ke_first_round,
    output logic                  rand_adv,
    output logic                  drdy_o,
    output logic                  busy
);

    localparam round_ctr_t ROUND_LAST = ROUND_BITS'(ROUNDS);
    localparam round_ctr_t ROUND_ONE  = ROUND_BITS'(1);

    stages_t    stage_next;
    round_ctr_t round_next;
    logic       ke_ok;
    logic       ke_ok_next;
    logic       params_start_next;
    logic       ke_start_next;
    logic       ke_first_round_next;
    logic       drdy_o_next;
    logic       busy_next;
    logic       sbox_go_c;
    logic       sbox_en_c;
    logic       sbox_all_done_c;

    assign sbox_go_c = (stage == ST_ADD_ROUND_KEY);
    assign sbox_en_c = (stage == ST_SUB_BYTES);

    clm_sbox_word_seq #(
        .WORDS(WORDS_PER_STATE)
    ) u_word_seq (
        .clk       (clk),
        .rst       (rst),
        .go        (sbox_go_c),
        .en        (sbox_en_c),
        .sbox_done (sbox_done),
        .word_sel  (word_sel),
        .sbox_start(sbox_start),
        .rand_adv  (rand_adv),
        .all_done_c(sbox_all_done_c)
    );

    // Next stage, round counter, key-ready flag and strobe decode.
    always_comb begin
        stage_next = stage;
        round_next = round;
        ke_ok_next = ke_ok;

        if (ke_done && tracks_key(stage)) begin
            ke_ok_next = 1'b1;
        end

        case (stage)
            ST_IDLE: begin
                if (drdy_i) begin
                    stage_next = ST_CALC_PARAMS;
                    round_next = '0;
                end
            end
            ST_CALC_PARAMS: begin
                if (params_done) begin
                    stage_next = ST_PREP_DATA;
                end
            end
            ST_PREP_DATA: begin
                stage_next = ST_ADD_ROUND_KEY;
            end
            ST_ADD_ROUND_KEY: begin
                stage_next = ST_SUB_BYTES;
                ke_ok_next = 1'b0;
                if (round < ROUND_LAST) begin
                    round_next = round + ROUND_ONE;
                end
            end
            ST_SUB_BYTES: begin
                if (sbox_all_done_c) begin
                    stage_next = ST_SHIFT_ROWS;
                end
            end
            ST_SHIFT_ROWS: begin
                if (round < ROUND_LAST) begin
                    stage_next = ST_MIX_COLS;
                end else if (ke_ok) begin
                    stage_next = ST_ADD_ROUND_KEY_LAST;
                end else begin
                    stage_next = ST_KEY_EXPAND_WAIT;
                end
            end
            ST_MIX_COLS: begin
                if (ke_ok || ke_done) begin
                    stage_next = ST_ADD_ROUND_KEY;
                end else begin
                    stage_next = ST_KEY_EXPAND_WAIT;
                end
            end
            ST_KEY_EXPAND_WAIT: begin
                // ke_ok covers a completion that coincided with the decision
                // cycle that sent us here.
                if (ke_done || ke_ok) begin
                    stage_next = (round == ROUND_LAST) ? ST_ADD_ROUND_KEY_LAST
                                                       : ST_ADD_ROUND_KEY;
                end
            end
            ST_ADD_ROUND_KEY_LAST: begin
                stage_next = ST_MOD_P;
            end
            ST_MOD_P: begin
                stage_next = ST_PREP_OUTPUT;
            end
            ST_PREP_OUTPUT: begin
                stage_next = ST_IDLE;
            end
            default: begin
                stage_next = ST_IDLE;
            end
        endcase

        params_start_next   = (stage == ST_IDLE) && drdy_i;
        ke_start_next       = (stage == ST_ADD_ROUND_KEY);
        ke_first_round_next = (stage == ST_ADD_ROUND_KEY) && (round_next == ROUND_ONE);
        drdy_o_next         = (stage_next == ST_PREP_OUTPUT);
        busy_next           = (stage_next != ST_IDLE);
    end

    // State, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage          <= ST_IDLE;
            round          <= '0;
            ke_ok          <= 1'b0;
            params_start   <= 1'b0;
            ke_start       <= 1'b0;
            ke_first_round <= 1'b0;
            drdy_o         <= 1'b0;
            busy           <= 1'b0;
        end else begin
            stage          <= stage_next;
            round          <= round_next;
            ke_ok          <= ke_ok_next;
            params_start   <= params_start_next;
            ke_start       <= ke_start_next;
            ke_first_round <= ke_first_round_next;
            drdy_o         <= drdy_o_next;
            busy           <= busy_next;
        end
    end

endmodule
